// File: rtl/core_reset_done_ctrl.sv
// core_reset_done_ctrl: releases N cores from reset one after another with a
// programmable delay, watches their dmem writes for completion, and counts the
// run cycles with an optional timeout. It can be restarted without an FPGA reset.
`timescale 1ns/1ps
module core_reset_done_ctrl #(
  parameter int NUM_CORES      = 4,
  parameter int RST_PIPE_DEPTH = 6,
  parameter int RST_STAGGER    = 0,
  parameter int DONE_ALL       = 1,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_locked,
  input  logic                   i_restart,
  input  logic [NUM_CORES*4-1:0] i_core_wr_en,
  output logic [NUM_CORES-1:0]   o_core_reset,
  output logic                   o_done,
  output logic                   o_timeout,
  output logic [NUM_CORES-1:0]   o_done_mask,
  output logic [CNT_W-1:0]       o_cycle_count,
  output logic [1:0]             o_state
);

  // The last core is released on this HOLD count, which also moves the FSM into RUN.
  localparam int T_LAST = RST_PIPE_DEPTH + (NUM_CORES - 1) * RST_STAGGER;
  localparam int HCNT_W = $clog2(T_LAST + 2);
  // Timeout compare value; only meaningful when the timeout is enabled.
  localparam logic [CNT_W-1:0] TO_LAST =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  state_e                state_q;
  logic [1:0]            sync_q;
  logic [HCNT_W-1:0]     hcnt_q;
  logic [NUM_CORES-1:0]  core_reset_q;
  logic [NUM_CORES-1:0]  mask_q;
  logic [NUM_CORES-1:0]  mask_d;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic                  done_q;
  logic                  timeout_q;
  logic [NUM_CORES-1:0]  wr_any;
  logic [NUM_CORES-1:0]  release_hit;
  logic                  done_cond;
  logic                  timeout_hit;

  // Per-core write detection and release-time match against the HOLD counter.
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
    assign wr_any[gi]      = |i_core_wr_en[4*gi +: 4];
    assign release_hit[gi] = (hcnt_q == HCNT_W'(RST_PIPE_DEPTH + gi * RST_STAGGER));
  end

  // Writes from a core that is still held in reset never count toward completion.
  always_comb begin
    mask_d      = mask_q | (wr_any & ~core_reset_q);
    done_cond   = (DONE_ALL != 0) ? (&mask_d) : (|mask_d);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (count_q == TO_LAST);
    count_d     = (&count_q) ? count_q : count_q + 1'b1;
  end

  // Two-flop synchroniser so the FSM leaves reset cleanly on the clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], 1'b1};
  end

  // Sequencer FSM: HOLD counts out the staggered releases, RUN watches for done/timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_HOLD;
      hcnt_q       <= '0;
      core_reset_q <= '1;
      mask_q       <= '0;
      count_q      <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else if (!sync_q[1] || i_restart || !i_locked) begin
      // Synchronised reset, explicit restart and loss of lock all rewind the sequence.
      state_q      <= ST_HOLD;
      hcnt_q       <= '0;
      core_reset_q <= '1;
      mask_q       <= '0;
      count_q      <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          hcnt_q       <= hcnt_q + 1'b1;
          core_reset_q <= core_reset_q & ~release_hit;
          if (hcnt_q == HCNT_W'(T_LAST)) state_q <= ST_RUN;
        end
        ST_RUN: begin
          count_q <= count_d;
          mask_q  <= mask_d;
          // Done takes priority over a timeout landing on the same edge.
          if (done_cond) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (timeout_hit) begin
            timeout_q <= 1'b1;
            state_q   <= ST_TIMEOUT;
          end
        end
        default: begin
          // DONE / TIMEOUT: everything frozen, cores keep running.
        end
      endcase
    end
  end

  assign o_core_reset  = core_reset_q;
  assign o_done        = done_q;
  assign o_timeout     = timeout_q;
  assign o_done_mask   = mask_q;
  assign o_cycle_count = count_q;
  assign o_state       = state_q;

endmodule
